// File: rtl/mmio_timer_responder.sv
// Memory-mapped countdown timer, LED register and synchronized switch input
// that answers CPU bus cycles on the shared tri-state data bus.
module mmio_timer_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          PRESCALE  = 1
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  input  logic        re_L,
  input  logic        we_L,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        expired
);

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_RELOAD = 3'd1,
    REG_COUNT  = 3'd2,
    REG_STATUS = 3'd3,
    REG_LED    = 3'd4,
    REG_SW     = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_e;

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic        en, auto_rl, exp_flag;
  logic [15:0] reload, count, led, pre_cnt;
  logic [15:0] sw_meta, sw_sync;
  logic [15:0] rdata;
  reg_e        offset;
  logic        hit, rd_hit, wr_hit;
  logic        wr_ctrl, wr_reload, wr_count, wr_led, rd_status;
  logic        tick, expire;

  assign offset    = reg_e'(address[2:0]);
  assign hit       = (address[15:3] == BASE_ADDR[15:3]);
  assign wr_hit    = hit & ~we_L;
  assign rd_hit    = hit & ~re_L & we_L;
  assign wr_ctrl   = wr_hit & (offset == REG_CTRL);
  assign wr_reload = wr_hit & (offset == REG_RELOAD);
  assign wr_count  = wr_hit & (offset == REG_COUNT);
  assign wr_led    = wr_hit & (offset == REG_LED);
  assign rd_status = rd_hit & (offset == REG_STATUS);

  assign tick   = en & (pre_cnt == PRE_LAST);
  // A COUNT write in the tick cycle suppresses both the decrement and the expiry.
  assign expire = tick & (count == 16'd0) & ~wr_count;

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    rdata = 16'h0000;
    case (offset)
      REG_CTRL:   rdata = {14'd0, auto_rl, en};
      REG_RELOAD: rdata = reload;
      REG_COUNT:  rdata = count;
      REG_STATUS: rdata = {15'd0, exp_flag};
      REG_LED:    rdata = led;
      REG_SW:     rdata = sw_sync;
      default:    rdata = 16'h0000;
    endcase
  end

  // Reset gates the driver directly so the bus is released without waiting for a clock.
  assign data = (rd_hit & reset_L) ? rdata : 16'bz;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      exp_flag <= 1'b0;
      reload   <= 16'h0000;
      count    <= 16'h0000;
      led      <= 16'h0000;
      pre_cnt  <= 16'h0000;
      sw_meta  <= 16'h0000;
      sw_sync  <= 16'h0000;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;

      if (wr_ctrl || !en || tick) pre_cnt <= 16'h0000;
      else                        pre_cnt <= pre_cnt + 16'd1;

      if (wr_count)                count <= data;
      else if (tick) begin
        if (count != 16'd0)        count <= count - 16'd1;
        else if (auto_rl)          count <= reload;
      end

      // Expiry outranks a same-cycle STATUS read-clear.
      if (expire)         exp_flag <= 1'b1;
      else if (rd_status) exp_flag <= 1'b0;

      if (wr_ctrl) begin
        en      <= data[0];
        auto_rl <= data[1];
      end else if (expire && !auto_rl) begin
        en <= 1'b0;
      end

      if (wr_reload) reload <= data;
      if (wr_led)    led    <= data;
    end
  end

  assign led_out = led;
  assign expired = exp_flag;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Randomized bench for mmio_timer_responder: PRESCALE=1 and PRESCALE=4 instances
// share one stimulus stream and are compared cycle by cycle to a bus-level model.
module tb_mmio_timer_responder;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] IDLE = 16'hFFFF;  // pulled-up bus value when nobody drives

  logic        clock = 1'b0;
  logic        reset_L;
  logic [15:0] address, wdata, sw_in;
  logic        re_L, we_L;
  tri1  [15:0] data1, data4;
  logic [15:0] led1, led4;
  logic        exp1, exp4;

  assign data1 = (!we_L) ? wdata : 16'bz;
  assign data4 = (!we_L) ? wdata : 16'bz;

  always #5 clock = ~clock;

  mmio_timer_responder #(.BASE_ADDR(BASE), .PRESCALE(1)) u_p1 (
    .clock(clock), .reset_L(reset_L), .address(address), .data(data1),
    .re_L(re_L), .we_L(we_L), .sw_in(sw_in), .led_out(led1), .expired(exp1)
  );

  mmio_timer_responder #(.BASE_ADDR(BASE), .PRESCALE(4)) u_p4 (
    .clock(clock), .reset_L(reset_L), .address(address), .data(data4),
    .re_L(re_L), .we_L(we_L), .sw_in(sw_in), .led_out(led4), .expired(exp4)
  );

  // Architectural view of one peripheral; "ticks_seen" counts enabled cycles
  // since the last prescaler restart.
  typedef struct {
    bit          en, auto_rl, exp_flag;
    int unsigned reload, count, led, ticks_seen;
    int unsigned sw_hist[$];
  } model_t;

  model_t      m[2];
  int unsigned pres[2] = '{1, 4};
  logic [15:0] obs_d[2];
  logic        obs_e[2];
  int          total = 0;
  int          pass_cnt = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic model_t model_reset();
    model_t s;
    s.en = 0; s.auto_rl = 0; s.exp_flag = 0;
    s.reload = 0; s.count = 0; s.led = 0; s.ticks_seen = 0;
    s.sw_hist = '{0, 0};
    return s;
  endfunction

  function automatic bit in_window();
    return (address >= BASE) && (address <= BASE + 16'd7);
  endfunction

  // Value expected on the bus this cycle (bench drive, register read, or pull-up).
  function automatic logic [15:0] bus_value(input model_t s);
    int unsigned off = int'(address) - int'(BASE);
    if (!we_L) return wdata;
    if (!in_window() || re_L) return IDLE;
    case (off)
      0: return {14'd0, s.auto_rl, s.en};
      1: return 16'(s.reload);
      2: return 16'(s.count);
      3: return {15'd0, s.exp_flag};
      4: return 16'(s.led);
      5: return 16'(s.sw_hist[0]);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic model_t model_step(input model_t s, input int unsigned p);
    model_t      n = s;
    int unsigned off = int'(address) - int'(BASE);
    bit          wr = in_window() && !we_L;
    bit          rd = in_window() && !re_L && we_L;
    bit          tick = s.en && ((s.ticks_seen % p) == p - 1);
    bit          fired = 0;
    if (tick && !(wr && off == 2)) begin
      if (s.count > 0) n.count = s.count - 1;
      else begin
        fired = 1;
        n.exp_flag = 1;
        if (s.auto_rl) n.count = s.reload;
        else n.en = 0;
      end
    end
    if (rd && off == 3 && !fired) n.exp_flag = 0;
    if ((wr && off == 0) || !s.en) n.ticks_seen = 0;
    else n.ticks_seen = s.ticks_seen + 1;
    if (wr) begin
      case (off)
        0: begin n.en = wdata[0]; n.auto_rl = wdata[1]; end
        1: n.reload = wdata;
        2: n.count = wdata;
        4: n.led = wdata;
        default: ;
      endcase
    end
    void'(n.sw_hist.pop_front());
    n.sw_hist.push_back(sw_in);
    return n;
  endfunction

  task automatic cycle(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
    address = a; re_L = r; we_L = w; wdata = d;
    @(negedge clock);
    obs_d[0] = data1; obs_d[1] = data4;
    obs_e[0] = exp1;  obs_e[1] = exp4;
    check("bus_p1", data1, bus_value(m[0]));
    check("bus_p4", data4, bus_value(m[1]));
    check("led_p1", led1, 16'(m[0].led));
    check("led_p4", led4, 16'(m[1].led));
    check("exp_p1", {15'd0, exp1}, {15'd0, m[0].exp_flag});
    check("exp_p4", {15'd0, exp4}, {15'd0, m[1].exp_flag});
    @(posedge clock);
    for (int k = 0; k < 2; k++) m[k] = model_step(m[k], pres[k]);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cycle(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [15:0] a);
    cycle(a, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic mid_reset();
    address = BASE + 16'd4; re_L = 0; we_L = 1;
    #2 reset_L = 0;
    #1;
    check("rst_bus_p1", data1, IDLE);
    check("rst_bus_p4", data4, IDLE);
    check("rst_led_p1", led1, 16'h0000);
    check("rst_exp_p4", {15'd0, exp4}, 16'h0000);
    for (int k = 0; k < 2; k++) m[k] = model_reset();
    @(posedge clock);
    #1 reset_L = 1;
  endtask

  initial begin
    reset_L = 0; address = BASE + 16'd4; re_L = 0; we_L = 1; wdata = 0; sw_in = 0;
    for (int k = 0; k < 2; k++) m[k] = model_reset();
    #3;
    check("por_bus", data1, IDLE);
    check("por_led", led1, 16'h0000);
    check("por_exp", {15'd0, exp1}, 16'h0000);
    @(posedge clock);
    #1 reset_L = 1;

    for (int i = 0; i < 8; i++) begin
      rd(BASE + 16'(i));
      check("reset_reg_p1", obs_d[0], 16'h0000);
      check("reset_reg_p4", obs_d[1], 16'h0000);
    end
    cycle(16'h1234, 1'b0, 1'b1, 16'h0000);
    check("miss_released", obs_d[0], IDLE);
    cycle(BASE + 16'd4, 1'b1, 1'b1, 16'h0000);
    check("no_re_released", obs_d[0], IDLE);

    // Auto-reload countdown with one tick per cycle.
    wr(BASE + 16'd1, 16'd3);
    wr(BASE + 16'd2, 16'd3);
    wr(BASE + 16'd0, 16'h0003);
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 16'd2);
      check("auto_count", obs_d[0], 16'(3 - (i % 4)));
      check("auto_exp", {15'd0, obs_e[0]}, {15'd0, 1'(i >= 4)});
    end
    wr(BASE + 16'd0, 16'h0000);
    rd(BASE + 16'd3);
    check("status_set", obs_d[0], 16'h0001);
    rd(BASE + 16'd3);
    check("status_cleared", obs_d[0], 16'h0000);

    // One-shot: expiry disables the timer and leaves COUNT at zero.
    wr(BASE + 16'd2, 16'd2);
    wr(BASE + 16'd0, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      rd(BASE + 16'd2);
      check("oneshot_count", obs_d[0], 16'(2 - i));
    end
    rd(BASE + 16'd0);
    check("oneshot_ctrl", obs_d[0], 16'h0000);
    check("oneshot_exp", {15'd0, obs_e[0]}, 16'h0001);
    rd(BASE + 16'd2);
    check("oneshot_hold", obs_d[0], 16'h0000);
    rd(BASE + 16'd3);
    rd(BASE + 16'd3);
    check("oneshot_clear", obs_d[0], 16'h0000);

    // STATUS read in the very cycle the timer expires.
    wr(BASE + 16'd2, 16'd1);
    wr(BASE + 16'd0, 16'h0001);
    rd(BASE + 16'd2);
    rd(BASE + 16'd3);
    check("aligned_read", obs_d[0], 16'h0000);
    rd(BASE + 16'd3);
    check("aligned_kept", obs_d[0], 16'h0001);
    rd(BASE + 16'd3);
    check("aligned_clear", obs_d[0], 16'h0000);

    // Prescaled instance: four cycles per tick.
    wr(BASE + 16'd0, 16'h0000);
    wr(BASE + 16'd2, 16'd1);
    wr(BASE + 16'd0, 16'h0001);
    for (int i = 0; i < 9; i++) begin
      rd(BASE + 16'd2);
      check("pre4_count", obs_d[1], 16'(i < 4 ? 1 : 0));
      check("pre4_exp", {15'd0, obs_e[1]}, {15'd0, 1'(i >= 8)});
    end
    wr(BASE + 16'd1, 16'd9);
    wr(BASE + 16'd2, 16'd9);
    wr(BASE + 16'd0, 16'h0003);
    for (int i = 0; i < 3; i++) rd(BASE + 16'd2);
    check("pre4_before_tick", obs_d[1], 16'd9);
    wr(BASE + 16'd2, 16'd5);
    rd(BASE + 16'd2);
    check("pre4_write_wins", obs_d[1], 16'd5);

    // LED register, switch synchronizer latency, and simultaneous re/we.
    wr(BASE + 16'd4, 16'hA5A5);
    check("led_out", led1, 16'hA5A5);
    sw_in = 16'h00F0;
    rd(BASE + 16'd5);
    rd(BASE + 16'd5);
    check("sw_not_yet", obs_d[0], 16'h0000);
    rd(BASE + 16'd5);
    check("sw_visible", obs_d[0], 16'h00F0);
    cycle(BASE + 16'd4, 1'b0, 1'b0, 16'h1234);
    check("both_low_bus", obs_d[0], 16'h1234);
    check("both_low_led", led1, 16'h1234);

    // Random traffic, with occasional asynchronous reset mid-run.
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] a, d;
      int          op;
      if ($urandom_range(0, 149) == 0) begin
        mid_reset();
        continue;
      end
      a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 7));
      d  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) sw_in = 16'($urandom);
      if (op <= 3)      cycle(a, 1'b0, 1'b1, d);
      else if (op <= 5) cycle(a, 1'b1, 1'b0, d);
      else if (op == 6) cycle(a, 1'b0, 1'b0, d);
      else              cycle(a, 1'b1, 1'b1, d);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
